ps2_host_sender: RTL

//  Host-to-keyboard PS/2 transmitter: the opposite direction of the scancode receive

---
 rtl/ps2_host_sender.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_sender.sv
// ps2_host_sender
//   Host-to-device PS/2 transmitter. Sends one command byte to the keyboard:
//   clock inhibit, request-to-send, 8 data bits LSB first, odd parity, stop,
//   then samples the device acknowledge. Only open-drain enables are driven;
//   the pads belong to the top level.
//
// Ports
//   clk         system clock (shared with the PS/2 receive logic)
//   rst_n       asynchronous reset, active low
//   send        1-cycle request; din is sampled when idle
//   din[7:0]    command byte
//   busy        high from accepted send until done/error
//   done        1-cycle pulse: frame sent and ACK seen
//   error       1-cycle pulse: timeout or missing ACK
//   rx_inhibit  copy of busy; tells the scancode receiver to ignore the bus
//   ps2clk_in   raw PS/2 clock pad (asynchronous)
//   ps2dat_in   raw PS/2 data pad (asynchronous)
//   ps2clk_oe   1 = pull PS/2 clock low
//   ps2dat_oe   1 = pull PS/2 data low
module ps2_host_sender #(
  parameter int INHIBIT_CYCLES = 2800,
  parameter int TIMEOUT_CYCLES = 420000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send,
  input  logic [7:0] din,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       rx_inhibit,
  input  logic       ps2clk_in,
  input  logic       ps2dat_in,
  output logic       ps2clk_oe,
  output logic       ps2dat_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FL_W  = $clog2(FILTER_LEN + 1);

  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SHIFT,
    S_ACK,
    S_WAITREL
  } state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  logic            ps2clk_p0, ps2clk_p1;
  logic            ps2dat_p0, ps2dat_p1;
  logic            fclk;
  logic [FL_W-1:0] flt_cnt;
  logic            fall;

  state_t           state;
  logic [9:0]       shreg;
  logic [3:0]       bitcnt;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             ack_ok;

  assign rx_inhibit = busy;

  // ---- stage p0/p1: pad synchronisers, clock glitch filter, fall strobe ----
  // Idle bus is high, so the synchronisers and filter come out of reset at 1
  // to avoid a spurious edge right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps2clk_p0 <= 1'b1;
      ps2clk_p1 <= 1'b1;
      ps2dat_p0 <= 1'b1;
      ps2dat_p1 <= 1'b1;
      fclk      <= 1'b1;
      flt_cnt   <= '0;
      fall      <= 1'b0;
    end else begin
      ps2clk_p0 <= ps2clk_in;
      ps2clk_p1 <= ps2clk_p0;
      ps2dat_p0 <= ps2dat_in;
      ps2dat_p1 <= ps2dat_p0;
      fall      <= 1'b0;
      if (ps2clk_p1 != fclk) begin
        // Accept the new level on the FILTER_LEN-th consecutive differing cycle.
        if (flt_cnt == FL_LAST) begin
          fclk    <= ps2clk_p1;
          flt_cnt <= '0;
          fall    <= ~ps2clk_p1;
        end else begin
          flt_cnt <= flt_cnt + 1'b1;
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  // ---- stage p2: frame sequencer with registered outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bitcnt    <= '0;
      inh_cnt   <= '0;
      to_cnt    <= '0;
      ack_ok    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      ps2clk_oe <= 1'b0;
      ps2dat_oe <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        S_IDLE: begin
          ps2clk_oe <= 1'b0;
          ps2dat_oe <= 1'b0;
          if (send) begin
            shreg     <= {1'b1, odd_parity(din), din};
            busy      <= 1'b1;
            ps2clk_oe <= 1'b1;
            inh_cnt   <= '0;
            state     <= S_INHIBIT;
          end
        end

        // Falls seen here are our own clock pull-down and are ignored.
        S_INHIBIT: begin
          if (inh_cnt == INH_LAST) begin
            inh_cnt   <= '0;
            ps2dat_oe <= 1'b1;
            state     <= S_RTS;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end

        S_RTS: begin
          ps2clk_oe <= 1'b0;
          bitcnt    <= '0;
          to_cnt    <= '0;
          state     <= S_SHIFT;
        end

        S_SHIFT, S_ACK, S_WAITREL: begin
          if (to_cnt == TO_LAST) begin
            ps2clk_oe <= 1'b0;
            ps2dat_oe <= 1'b0;
            error     <= 1'b1;
            busy      <= 1'b0;
            to_cnt    <= '0;
            state     <= S_IDLE;
          end else begin
            to_cnt <= fall ? '0 : to_cnt + 1'b1;
            if (state == S_SHIFT) begin
              if (fall) begin
                bitcnt <= bitcnt + 1'b1;
                if (bitcnt < 4'd9) begin
                  // Falls 1..9 present d0..d7 then parity.
                  ps2dat_oe <= ~shreg[0];
                  shreg     <= {1'b0, shreg[9:1]};
                end else if (bitcnt == 4'd9) begin
                  ps2dat_oe <= 1'b0;
                end else begin
                  state <= S_ACK;
                end
              end
            end else if (state == S_ACK) begin
              // Device still holds data low here if it acknowledged.
              ack_ok <= ~ps2dat_p1;
              state  <= S_WAITREL;
            end else begin
              if (fclk && ps2dat_p1) begin
                busy  <= 1'b0;
                done  <= ack_ok;
                error <= ~ack_ok;
                state <= S_IDLE;
              end
            end
          end
        end

        default: begin
          ps2clk_oe <= 1'b0;
          ps2dat_oe <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
